// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data ports share one memory port.
// Data wins ties unless a waiting fetch has been passed over STARVE_LIMIT times.
//   state  | meaning
//   IDLE   | no transaction, arbitrate on this cycle's requests
//   BUSY_I | fetch granted, memory port driven with latched fields
//   BUSY_D | data access granted, memory port driven with latched fields
//   RESP   | one-cycle ack to the granted port, then back to IDLE
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ack_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          err_q, err_d;
  logic          data_wins;
  logic          is_busy;
  logic          finish;
  logic [31:0]   resp_data;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    data_wins   = d_req_i && !(i_req_i && (starve_q == STARVE_MAX));
    is_busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
    finish      = 1'b0;
    resp_data   = 32'h0;

    case (state_q)
      IDLE: begin
        if (data_wins) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          tmo_d       = '0;
          if (!i_req_i) starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
        end else if (i_req_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr_i;
          mem_wdata_d = 32'h0;
          tmo_d       = '0;
          starve_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // A real ack in the last allowed cycle beats the timeout.
        if (mem_ack_i) begin
          finish    = 1'b1;
          resp_data = mem_we_q ? 32'h0 : mem_rdata_i;
        end else if (tmo_q == TMO_LAST) begin
          finish    = 1'b1;
          err_d     = 1'b1;
          tmo_d     = tmo_q + 1'b1;
        end else begin
          tmo_d     = tmo_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (is_busy && finish) begin
      state_d   = RESP;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (state_q == BUSY_D) begin
        d_ack_d   = 1'b1;
        d_rdata_d = resp_data;
      end else begin
        i_ack_d   = 1'b1;
        i_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= 32'h0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_ack_o     = i_ack_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;
  assign stall_o     = (i_req_i & ~i_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vector table, directed corner sequences, then
// random traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_ack_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] mem_rdata;
    logic        e_mem_req, e_mem_we, e_i_ack, e_d_ack, e_err;
    logic [31:0] e_addr, e_i_rdata, e_d_rdata;
  } vec_t;

  function automatic vec_t mkv(input logic ir, input logic dr, input logic dw, input logic ma,
                               input logic [31:0] rd, input logic emr, input logic emw,
                               input logic eia, input logic eda, input logic ee,
                               input logic [31:0] ea, input logic [31:0] eir,
                               input logic [31:0] edr);
    vec_t v;
    v.i_req = ir; v.d_req = dr; v.d_we = dw; v.mem_ack = ma; v.mem_rdata = rd;
    v.e_mem_req = emr; v.e_mem_we = emw; v.e_i_ack = eia; v.e_d_ack = eda; v.e_err = ee;
    v.e_addr = ea; v.e_i_rdata = eir; v.e_d_rdata = edr;
    return v;
  endfunction

  vec_t vecs[10];

  // reference model state for the random phase
  int          starve, phase, elapsed, lat;
  logic        win_d, e_we, e_mr, e_ia, e_da, e_err;
  logic [31:0] e_addr, e_wdata, e_ir, e_dr;

  initial begin
    logic        prev_ia, prev_da;
    logic [31:0] ga[5];
    int          n_gr, busy, we_cnt;
    logic        prev_mr;

    rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = 32'h0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = 32'h0; d_wdata_i = 32'h0; mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    tick(); tick();
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_i_ack", i_ack_o, 1'b0);
    chk1("rst_d_ack", d_ack_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk32("rst_i_rdata", i_rdata_o, 32'h0);
    chk32("rst_d_rdata", d_rdata_o, 32'h0);
    chk32("rst_mem_addr", mem_addr_o, 32'h0);
    rst_i = 1'b0;

    // inputs during a cycle -> registered outputs after its closing edge
    vecs[0] = mkv(H, L, L, L, 32'h0,        H, L, L, L, L, 32'h10, 32'h0,        32'h0);
    vecs[1] = mkv(H, L, L, H, 32'hDEADBEEF, L, L, H, L, L, 32'h0,  32'hDEADBEEF, 32'h0);
    vecs[2] = mkv(L, L, L, H, 32'h11111111, L, L, L, L, L, 32'h0,  32'hDEADBEEF, 32'h0);
    vecs[3] = mkv(L, L, L, H, 32'h22222222, L, L, L, L, L, 32'h0,  32'hDEADBEEF, 32'h0);
    vecs[4] = mkv(H, H, L, L, 32'h0,        H, L, L, L, L, 32'h20, 32'hDEADBEEF, 32'h0);
    vecs[5] = mkv(H, H, L, H, 32'h00001234, L, L, L, H, L, 32'h0,  32'hDEADBEEF, 32'h1234);
    vecs[6] = mkv(H, L, L, L, 32'h0,        L, L, L, L, L, 32'h0,  32'hDEADBEEF, 32'h1234);
    vecs[7] = mkv(H, L, L, L, 32'h0,        H, L, L, L, L, 32'h10, 32'hDEADBEEF, 32'h1234);
    vecs[8] = mkv(H, L, L, H, 32'hCAFEF00D, L, L, H, L, L, 32'h0,  32'hCAFEF00D, 32'h1234);
    vecs[9] = mkv(L, L, L, L, 32'h0,        L, L, L, L, L, 32'h0,  32'hCAFEF00D, 32'h1234);

    prev_ia = 1'b0; prev_da = 1'b0;
    i_addr_i = 32'h10; d_addr_i = 32'h20; d_wdata_i = 32'h77;
    for (int k = 0; k < 10; k++) begin
      i_req_i = vecs[k].i_req; d_req_i = vecs[k].d_req; d_we_i = vecs[k].d_we;
      mem_ack_i = vecs[k].mem_ack; mem_rdata_i = vecs[k].mem_rdata;
      #1 chk1("tbl_stall", stall_o, (vecs[k].i_req & ~prev_ia) | (vecs[k].d_req & ~prev_da));
      tick();
      chk1("tbl_mem_req", mem_req_o, vecs[k].e_mem_req);
      chk1("tbl_mem_we", mem_we_o, vecs[k].e_mem_we);
      chk1("tbl_i_ack", i_ack_o, vecs[k].e_i_ack);
      chk1("tbl_d_ack", d_ack_o, vecs[k].e_d_ack);
      chk1("tbl_err", err_o, vecs[k].e_err);
      chk32("tbl_i_rdata", i_rdata_o, vecs[k].e_i_rdata);
      chk32("tbl_d_rdata", d_rdata_o, vecs[k].e_d_rdata);
      if (vecs[k].e_mem_req) chk32("tbl_mem_addr", mem_addr_o, vecs[k].e_addr);
      prev_ia = vecs[k].e_i_ack; prev_da = vecs[k].e_d_ack;
    end

    // starvation: data held high for back-to-back transactions, fetch waiting
    i_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; mem_rdata_i = 32'h13579BDF;
    n_gr = 0; prev_mr = 1'b0;
    for (int c = 0; c < 60 && n_gr < 5; c++) begin
      mem_ack_i = mem_req_o;
      tick();
      if (mem_req_o && !prev_mr) begin
        ga[n_gr] = mem_addr_o;
        n_gr++;
      end
      prev_mr = mem_req_o;
    end
    chk32("starve_grant_count", 32'(n_gr), 32'd5);
    for (int g = 0; g < 5; g++)
      chk32("starve_grant_order", ga[g], (g < 4) ? 32'h20 : 32'h10);
    d_req_i = 1'b0; mem_ack_i = 1'b1;
    tick();
    chk1("starve_fetch_ack", i_ack_o, 1'b1);
    chk32("starve_fetch_rdata", i_rdata_o, 32'h13579BDF);
    i_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();

    // write with three wait cycles
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0; d_wdata_i = 32'h5;
    mem_rdata_i = 32'hFFFFFFFF;
    tick();
    we_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_we_o) we_cnt++;
      if (c == 0) begin
        chk32("wr_addr", mem_addr_o, 32'h0);
        chk32("wr_wdata", mem_wdata_o, 32'h5);
      end
      chk1("wr_no_early_ack", d_ack_o, 1'b0);
      mem_ack_i = (c == 3);
      tick();
    end
    chk32("wr_we_cycles", 32'(we_cnt), 32'd4);
    chk1("wr_ack", d_ack_o, 1'b1);
    chk32("wr_rdata_zero", d_rdata_o, 32'h0);
    chk1("wr_we_dropped", mem_we_o, 1'b0);
    d_req_i = 1'b0; d_we_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    chk1("wr_ack_one_cycle", d_ack_o, 1'b0);

    // no memory ack: timeout abort
    i_req_i = 1'b1; i_addr_i = 32'h44; mem_rdata_i = 32'hABCD;
    tick();
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      if (!mem_req_o) break;
      busy++;
      tick();
    end
    chk32("tmo_busy_cycles", 32'(busy), 32'd15);
    chk1("tmo_ack", i_ack_o, 1'b1);
    chk1("tmo_err", err_o, 1'b1);
    chk32("tmo_rdata", i_rdata_o, 32'h0);
    i_req_i = 1'b0;
    tick();
    chk1("tmo_err_pulse", err_o, 1'b0);
    chk1("tmo_idle", mem_req_o, 1'b0);

    // ack in the same cycle the timeout would fire
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h88; mem_rdata_i = 32'h600D;
    tick();
    for (int c = 0; c < 15; c++) begin
      mem_ack_i = (c == 14);
      tick();
    end
    chk1("tie_ack", d_ack_o, 1'b1);
    chk1("tie_no_err", err_o, 1'b0);
    chk32("tie_rdata", d_rdata_o, 32'h600D);
    d_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();

    // reset during the second busy cycle
    d_req_i = 1'b1; d_addr_i = 32'h99;
    tick(); tick();
    chk1("rstb_busy", mem_req_o, 1'b1);
    rst_i = 1'b1;
    tick();
    chk1("rstb_mem_req", mem_req_o, 1'b0);
    chk1("rstb_no_ack", d_ack_o, 1'b0);
    chk1("rstb_no_err", err_o, 1'b0);
    rst_i = 1'b0;
    tick();
    chk1("rstb_regrant", mem_req_o, 1'b1);
    chk32("rstb_regrant_addr", mem_addr_o, 32'h99);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h7777;
    tick();
    chk1("rstb_fresh_ack", d_ack_o, 1'b1);
    chk32("rstb_fresh_rdata", d_rdata_o, 32'h7777);
    d_req_i = 1'b0; mem_ack_i = 1'b0;

    // random traffic against the transaction-level model
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; i_req_i = 1'b0;
    starve = 0; phase = 0; elapsed = 0; lat = 0; win_d = 1'b0;
    e_we = 1'b0; e_mr = 1'b0; e_ia = 1'b0; e_da = 1'b0; e_err = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; e_ir = 32'h0; e_dr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk1("rnd_mem_req", mem_req_o, e_mr);
      chk1("rnd_mem_we", mem_we_o, e_mr & e_we);
      if (e_mr) chk32("rnd_mem_addr", mem_addr_o, e_addr);
      if (e_mr && win_d) chk32("rnd_mem_wdata", mem_wdata_o, e_wdata);
      chk1("rnd_i_ack", i_ack_o, e_ia);
      chk1("rnd_d_ack", d_ack_o, e_da);
      chk1("rnd_err", err_o, e_err);
      chk32("rnd_i_rdata", i_rdata_o, e_ir);
      chk32("rnd_d_rdata", d_rdata_o, e_dr);

      if (e_ia || !i_req_i) begin
        i_req_i  = ($urandom_range(2, 0) == 0);
        i_addr_i = $urandom;
      end
      if (e_da || !d_req_i) begin
        d_req_i   = ($urandom_range(1, 0) == 0);
        d_we_i    = ($urandom_range(1, 0) == 1);
        d_addr_i  = $urandom;
        d_wdata_i = $urandom;
      end
      mem_rdata_i = $urandom;
      if (phase == 1) begin
        elapsed++;
        mem_ack_i = (elapsed == lat);
      end else begin
        mem_ack_i = ($urandom_range(3, 0) == 0);
      end
      #1 chk1("rnd_stall", stall_o, (i_req_i & ~e_ia) | (d_req_i & ~e_da));

      e_ia = 1'b0; e_da = 1'b0; e_err = 1'b0;
      if (phase == 0) begin
        if (d_req_i && !(i_req_i && starve == STARVE_LIMIT)) begin
          win_d = 1'b1; e_addr = d_addr_i; e_we = d_we_i; e_wdata = d_wdata_i;
          starve = i_req_i ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
        end else if (i_req_i) begin
          win_d = 1'b0; e_addr = i_addr_i; e_we = 1'b0; starve = 0;
        end
        if (i_req_i || d_req_i) begin
          phase = 1; elapsed = 0; lat = $urandom_range(18, 1); e_mr = 1'b1;
        end
      end else if (phase == 1) begin
        if (mem_ack_i || elapsed == TIMEOUT) begin
          phase = 2; e_mr = 1'b0;
          e_err = !mem_ack_i;
          if (win_d) begin
            e_da = 1'b1;
            e_dr = (mem_ack_i && !e_we) ? mem_rdata_i : 32'h0;
          end else begin
            e_ia = 1'b1;
            e_ir = mem_ack_i ? mem_rdata_i : 32'h0;
          end
        end
      end else begin
        phase = 0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while a fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: max BUSY cycles before abort.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports i_req_i (input, 1) and i_addr_i (input, 32): instruction-fetch request and address.
REQ-006 SHALL have ports i_ack_o (output, 1) and i_rdata_o (output, 32): fetch completion pulse and read data.
REQ-007 SHALL have ports d_req_i (1), d_we_i (1), d_addr_i (32), d_wdata_i (32), all inputs: data-port request, write enable, address, write data.
REQ-008 SHALL have ports d_ack_o (output, 1) and d_rdata_o (output, 32): data-port completion pulse and read data.
REQ-009 SHALL have outputs mem_req_o (1), mem_we_o (1), mem_addr_o (32), mem_wdata_o (32): shared memory port.
REQ-010 SHALL have inputs mem_rdata_i (32) and mem_ack_i (1): memory read data and completion.
REQ-011 SHALL have output stall_o (1): pipeline stall request.
REQ-012 SHALL have output err_o (1): timeout indication, pulsed with the ack.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-014 IDLE: d_req_i only -> BUSY_D; i_req_i only -> BUSY_I; neither -> IDLE.
REQ-015 IDLE, both requesting: BUSY_D unless starve count == STARVE_LIMIT, then BUSY_I.
REQ-016 On the grant edge SHALL latch addr/we/wdata of the winner; d_we_i is ignored for fetch grants, so mem_we_o = 0.
REQ-017 In BUSY_x, mem_req_o SHALL be 1 and drive the latched fields; in IDLE and RESP mem_req_o and mem_we_o SHALL be 0.
REQ-018 BUSY_x with mem_ack_i = 1 -> RESP; the granted port's rdata SHALL register mem_rdata_i (0 for writes).
REQ-019 In RESP, exactly the granted port's ack SHALL be 1 for one cycle, then -> IDLE unconditionally.
REQ-020 Minimum turnaround SHALL be: req in cycle 0, mem_req_o in cycle 1, ack in cycle 2 (zero-wait memory), next grant possible at the cycle-3 edge.
REQ-021 Requesters SHALL hold req and fields stable until ack; a req still high in the IDLE cycle after ack is a new transaction.
REQ-022 A timeout counter SHALL clear on grant and increment each BUSY cycle without mem_ack_i.
REQ-023 When the timeout count reaches TIMEOUT without mem_ack_i -> RESP with rdata = 0 and err_o = 1 together with the ack.
REQ-024 mem_ack_i and the timeout in the same cycle: mem_ack_i wins, err_o = 0.
REQ-025 The starve counter SHALL increment on a data grant with i_req_i = 1, and clear on any fetch grant or a data grant with i_req_i = 0; it saturates at STARVE_LIMIT.
REQ-026 mem_ack_i outside BUSY SHALL be ignored.
REQ-027 stall_o SHALL equal (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o), combinational.
REQ-028 i_rdata_o/d_rdata_o SHALL hold their last value until that port's next RESP.

Reset
REQ-029 rst_i = 1 at a clock edge SHALL force IDLE, zero both counters, and set every registered output (acks, rdata, mem_*, err_o) to 0.
REQ-030 Reset mid-BUSY SHALL abandon the transaction: mem_req_o = 0 the next cycle, no ack, no err_o.
REQ-031 rst_i SHALL dominate all other inputs in the same cycle.

Verification
REQ-032 Zero-wait fetch: i_req_i = 1, addr 0x10, memory returns 0xDEADBEEF with mem_ack_i in cycle 1 -> i_ack_o = 1 and i_rdata_o = 0xDEADBEEF in cycle 2.
REQ-033 Simultaneous i_req_i/d_req_i from IDLE -> data granted first; fetch granted in the IDLE after the data RESP.
REQ-034 d_req_i held high for 5 back-to-back transactions while i_req_i waits -> 4 data grants, then a fetch grant.
REQ-035 Data write 0x5 to 0x0 with mem_ack_i after 3 wait cycles -> mem_we_o = 1 for 4 cycles, d_ack_o one cycle later, d_rdata_o = 0.
REQ-036 mem_ack_i never asserted -> after 15 BUSY cycles, ack and err_o = 1 for one cycle, rdata = 0, then IDLE.
REQ-037 rst_i pulsed in the second BUSY cycle -> next cycle IDLE, mem_req_o = 0, no ack; a fresh request afterward completes normally.
